// File: rtl/ps2_host_tx_if.sv
// Command and pad bundle for the PS/2 host transmitter.
// slave is the transmitter; master is the command/pad side.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       ps2_clk;
  logic       ps2_data;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       done;
  logic       ack_err;

  modport master (
    output tx_data, tx_start, ps2_clk, ps2_data,
    input  ps2_clk_oe, ps2_data_oe, busy, done, ack_err
  );

  modport slave (
    input  tx_data, tx_start, ps2_clk, ps2_data,
    output ps2_clk_oe, ps2_data_oe, busy, done, ack_err
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter, open-drain pull-low outputs.
// Define PS2_TX_TIMEOUT_EN to compile the device-clock watchdog.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input logic          clk,
  input logic          rst,
  ps2_host_tx_if.slave bus
);

  localparam int CW = $clog2(INHIBIT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    sh_q, sh_d;
  logic [3:0]    idx_q, idx_d;
  logic          ok_q, ok_d;
  logic [1:0]    csync_q, dsync_q, hist_q;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          clk_s, data_s, fall;

  assign clk_s  = csync_q[1];
  assign data_s = dsync_q[1];
  assign fall   = (hist_q == 2'b10);

  assign bus.ps2_clk_oe  = clk_oe_q;
  assign bus.ps2_data_oe = data_oe_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.ack_err     = err_q;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_q, wd_d;
  logic          wd_run;

  assign wd_run = state_q inside {SEND, ACK, WAIT_IDLE};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      idx_q     <= '0;
      ok_q      <= 1'b0;
      csync_q   <= 2'b11;
      dsync_q   <= 2'b11;
      hist_q    <= 2'b11;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      idx_q     <= idx_d;
      ok_q      <= ok_d;
      csync_q   <= {csync_q[0], bus.ps2_clk};
      dsync_q   <= {dsync_q[0], bus.ps2_data};
      hist_q    <= {hist_q[0], clk_s};
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    idx_d     = idx_q;
    ok_d      = ok_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
    wd_d      = wd_q;
`endif

    unique case (state_q)
      IDLE: begin
        // busy_q still high here means a result pulse is on the wire
        if (bus.tx_start && !busy_q) begin
          state_d = INHIBIT;
          cnt_d   = '0;
          sh_d    = {1'b1, ~^bus.tx_data, bus.tx_data};
        end
      end
      INHIBIT: begin
        if (cnt_q == CW'(INHIBIT_CYCLES - 1)) state_d = REQ;
        else cnt_d = cnt_q + 1'b1;
      end
      REQ: begin
        state_d = SEND;
        idx_d   = '0;
      end
      SEND: begin
        if (fall) begin
          data_oe_d = ~sh_q[0];
          sh_d      = {1'b0, sh_q[9:1]};
          idx_d     = idx_q + 1'b1;
          if (idx_q == 4'd9) state_d = ACK;
        end
      end
      ACK: begin
        if (fall) begin
          ok_d    = ~data_s;
          state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (clk_s && data_s) begin
          state_d = IDLE;
          done_d  = ok_q;
          err_d   = ~ok_q;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    if (state_q == REQ) wd_d = '0;
    if (wd_run) begin
      if (fall) begin
        wd_d = '0;
      end else if (wd_q == TW'(TIMEOUT_CYCLES)) begin
        state_d = IDLE;
        done_d  = 1'b0;
        err_d   = 1'b1;
        wd_d    = '0;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
`endif

    // Pad drives follow the state being entered, so they stay registered
    clk_oe_d = (state_d == INHIBIT) || (state_d == REQ);
    if (state_d == REQ) data_oe_d = 1'b1;
    else if (state_d inside {IDLE, INHIBIT, WAIT_IDLE}) data_oe_d = 1'b0;
    busy_d = (state_d != IDLE) || done_d || err_d;
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model.
// Timeout expectations depend on PS2_TX_TIMEOUT_EN.
module tb_ps2_host_tx;
  localparam int INH  = 100;
  localparam int TO   = 500;
  localparam int HALF = 40;

  localparam logic [10:0] EXP_ED = 11'b1_1_11101101_0;
  localparam logic [10:0] EXP_F4 = 11'b1_0_11110100_0;
  localparam logic [10:0] EXP_00 = 11'b1_1_00000000_0;

  logic clk = 1'b0;
  logic rst;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;

  int total = 0;
  int passed = 0;
  int cyc = 0;
  int n_done = 0;
  int n_err = 0;
  int run = 0;
  int last_run = 0;
  int fall_cyc = 0;
  int d0, e0, lat, n;
  logic [10:0] bits;
  bit ok, idle_ok;

  always #5 clk = ~clk;

  ps2_host_tx_if bus();

  assign bus.ps2_clk  = ~(bus.ps2_clk_oe | dev_clk_low);
  assign bus.ps2_data = ~(bus.ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always @(posedge clk) begin
    cyc++;
    if (bus.done) n_done++;
    if (bus.ack_err) n_err++;
    if (bus.ps2_clk_oe) run++;
    else if (run != 0) begin
      last_run = run;
      run = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic start(input logic [7:0] b);
    @(negedge clk);
    bus.tx_data = b;
    bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
    bus.tx_data = ~b;
  endtask

  task automatic wait_idle(output bit good);
    int k;
    k = 0;
    while (bus.busy !== 1'b0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    good = (k < 3000);
  endtask

  // Device side: waits for request-to-send, clocks out edges, samples
  // the line on each rising edge, optionally acks edge 11.
  task automatic dev_rx(input bit do_ack, input int stop_after,
                        output logic [10:0] rx, output bit good);
    int k;
    k = 0;
    rx = '1;
    good = 1'b0;
    while (!(bus.ps2_clk === 1'b1 && bus.ps2_data === 1'b0) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2000) return;
    good = 1'b1;
    repeat (HALF) @(negedge clk);
    rx[0] = bus.ps2_data;
    for (int e = 1; e <= 10; e++) begin
      if (e > stop_after) return;
      dev_clk_low = 1'b1;
      fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      rx[e] = bus.ps2_data;
      repeat (HALF) @(negedge clk);
    end
    if (stop_after < 11) return;
    if (do_ack) dev_data_low = 1'b1;
    repeat (HALF / 2) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  initial begin
    bus.tx_data = 8'h00;
    bus.tx_start = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_clk_oe", 32'(bus.ps2_clk_oe), 0);
    chk("rst_data_oe", 32'(bus.ps2_data_oe), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_ack_err", 32'(bus.ack_err), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 0xED acked
    d0 = n_done; e0 = n_err;
    start(8'hED);
    chk("ed_busy_rise", 32'(bus.busy), 1);
    chk("ed_clk_oe_rise", 32'(bus.ps2_clk_oe), 1);
    chk("ed_data_oe_inh", 32'(bus.ps2_data_oe), 0);
    dev_rx(1'b1, 11, bits, ok);
    chk("ed_rts", 32'(ok), 1);
    chk("ed_bits", 32'(bits), 32'(EXP_ED));
    wait_idle(idle_ok);
    chk("ed_idle", 32'(idle_ok), 1);
    chk("ed_done_cnt", n_done - d0, 1);
    chk("ed_err_cnt", n_err - e0, 0);

    // 0xF4 acked, inhibit length
    repeat (5) @(negedge clk);
    d0 = n_done; e0 = n_err;
    start(8'hF4);
    dev_rx(1'b1, 11, bits, ok);
    chk("f4_bits", 32'(bits), 32'(EXP_F4));
    chk("f4_clk_oe_len", last_run, INH + 1);
    wait_idle(idle_ok);
    chk("f4_idle", 32'(idle_ok), 1);
    chk("f4_done_cnt", n_done - d0, 1);

    // no ack at edge 11
    repeat (5) @(negedge clk);
    d0 = n_done; e0 = n_err;
    start(8'hF4);
    dev_rx(1'b0, 11, bits, ok);
    wait_idle(idle_ok);
    chk("nak_idle", 32'(idle_ok), 1);
    chk("nak_err_cnt", n_err - e0, 1);
    chk("nak_done_cnt", n_done - d0, 0);
    chk("nak_clk_oe", 32'(bus.ps2_clk_oe), 0);
    chk("nak_data_oe", 32'(bus.ps2_data_oe), 0);

    // second start while busy is dropped
    repeat (5) @(negedge clk);
    d0 = n_done; e0 = n_err;
    start(8'hED);
    fork
      dev_rx(1'b1, 11, bits, ok);
      begin
        repeat (300) @(negedge clk);
        bus.tx_data = 8'h55;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        bus.tx_data = 8'hAA;
      end
    join
    chk("ign_bits", 32'(bits), 32'(EXP_ED));
    wait_idle(idle_ok);
    chk("ign_idle", 32'(idle_ok), 1);
    chk("ign_done_cnt", n_done - d0, 1);
    repeat (200) @(negedge clk);
    chk("ign_no_restart", 32'(bus.busy), 0);

    // device stops after edge 4
    repeat (5) @(negedge clk);
    d0 = n_done; e0 = n_err;
    start(8'hED);
    dev_rx(1'b1, 4, bits, ok);
`ifdef PS2_TX_TIMEOUT_EN
    n = 0;
    while (bus.ack_err !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    lat = cyc - fall_cyc;
    chk("to_seen", 32'(n < 2000), 1);
    chk("to_latency", 32'(lat >= TO && lat <= TO + 15), 1);
    chk("to_clk_oe", 32'(bus.ps2_clk_oe), 0);
    chk("to_data_oe", 32'(bus.ps2_data_oe), 0);
    wait_idle(idle_ok);
    chk("to_idle", 32'(idle_ok), 1);
    chk("to_err_cnt", n_err - e0, 1);
`else
    repeat (TO + 200) @(negedge clk);
    chk("to_busy_held", 32'(bus.busy), 1);
    chk("to_err_cnt", n_err - e0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("to_rst_busy", 32'(bus.busy), 0);
`endif

    // reset during SEND after edge 6
    repeat (5) @(negedge clk);
    d0 = n_done; e0 = n_err;
    start(8'h00);
    dev_rx(1'b1, 6, bits, ok);
    chk("mid_data_oe_pre", 32'(bus.ps2_data_oe), 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_clk_oe", 32'(bus.ps2_clk_oe), 0);
    chk("mid_data_oe", 32'(bus.ps2_data_oe), 0);
    chk("mid_busy", 32'(bus.busy), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    chk("mid_no_pulse", (n_done - d0) + (n_err - e0), 0);
    chk("mid_bits_seen", 32'(bits[6:0]), 32'(EXP_00[6:0]));

    d0 = n_done; e0 = n_err;
    start(8'hF4);
    dev_rx(1'b1, 11, bits, ok);
    chk("post_bits", 32'(bits), 32'(EXP_F4));
    wait_idle(idle_ok);
    chk("post_idle", 32'(idle_ok), 1);
    chk("post_done_cnt", n_done - d0, 1);
    chk("post_err_cnt", n_err - e0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs) followed by the LED mask, or 0xF4 (enable scanning), using the PS/2 request-to-send sequence. It drives the shared PS/2 clock and data lines only through open-drain pull-low enables, and it sits beside the keyboard receiver on the same pins. The top level must hold the receiver idle while `busy` is high.

## Interface
- `INHIBIT_CYCLES`, default 10000: `clk` cycles the clock line is held low before the request (≥100 µs at 100 MHz).
- `TIMEOUT_CYCLES`, default 2000000: maximum `clk` cycles allowed between consecutive device clock falling edges. Active only when `PS2_TX_TIMEOUT_EN` is defined.
- `clk` in, 1: system clock. One clock; every register is on its posedge.
- `rst` in, 1: asynchronous active-high reset.
- `ps2_clk` in, 1: PS/2 clock line as seen at the pad (asynchronous).
- `ps2_data` in, 1: PS/2 data line as seen at the pad (asynchronous).
- `tx_data` in, 8: byte to send. Sampled on the cycle `tx_start` is accepted.
- `tx_start` in, 1: request to send. Accepted only in IDLE.
- `ps2_clk_oe` out, 1: 1 pulls the clock pad low; 0 releases it (high-Z).
- `ps2_data_oe` out, 1: 1 pulls the data pad low; 0 releases it.
- `busy` out, 1: high in every state except IDLE.
- `done` out, 1: one-cycle pulse when a transfer completes and the device acknowledged it.
- `ack_err` out, 1: one-cycle pulse when a transfer ends without acknowledge, or on timeout.

## Operation
- Input synchronisation: `ps2_clk` and `ps2_data` each pass through 2 flops.
- Falling-edge detect: a 2-bit history of the synchronised clock; a falling edge is the pattern `10`.
- On acceptance, latch `tx_data` into a shift register as {stop=1, parity, data[7:0]}. Parity is odd: `~^tx_data`.
- States and transitions:
  - IDLE: both OEs 0. `tx_start` → INHIBIT, and the counter clears.
  - INHIBIT: `ps2_clk_oe`=1, `ps2_data_oe`=0. Leave when the counter reaches `INHIBIT_CYCLES`-1 → REQ.
  - REQ (exactly 1 cycle): `ps2_clk_oe`=1, `ps2_data_oe`=1 (start bit 0). → SEND, bit index 0.
  - SEND: `ps2_clk_oe`=0. On each falling edge, `ps2_data_oe` ← ~shift[0], the register shifts right and the index increments.
    - Edges 1–8 present data bits LSB first.
    - Edge 9 presents parity.
    - Edge 10 presents stop: `ps2_data_oe`=0.
    - After edge 10 → ACK.
  - ACK: wait for the next falling edge (edge 11) and sample synchronised `ps2_data`. Sample 0 means acknowledged, 1 means ack error. Either way → WAIT_IDLE, with the result held in a flag.
  - WAIT_IDLE: both OEs 0. When the synchronised clock and data are both 1 → IDLE. In the same transition pulse `done` (flag ok) or `ack_err` (flag bad).
- `tx_start` while `busy` is ignored. No queueing.
- `tx_data` changes after acceptance have no effect on the transfer in progress.
- `rst` asserted at any time:
  - state returns to IDLE and both OEs drop to 0 immediately (asynchronously), releasing the bus;
  - no `done` or `ack_err` pulse is generated.

## Timing
- Reset values: `ps2_clk_oe`=0, `ps2_data_oe`=0, `busy`=0, `done`=0, `ack_err`=0. The synchroniser and edge-history flops reset to 1.
- `tx_start` high at edge N (in IDLE) → `busy`=1 and `ps2_clk_oe`=1 from edge N+1.
- `ps2_clk_oe` stays high for exactly `INHIBIT_CYCLES`+1 cycles: INHIBIT plus REQ.
- `ps2_data_oe` rises on the REQ cycle, one cycle before the clock is released.
- Edge-detect latency: a pad falling edge causes a `ps2_data_oe` update 3 `clk` cycles later (2-flop synchroniser plus the history register). This is well inside the device's half-period of ≥30 µs.
- `done`/`ack_err` is a single cycle. `busy` falls on the cycle after the pulse.
- All outputs are registered.

## Configuration
- `PS2_TX_TIMEOUT_EN` defined:
  - a watchdog counter clears on every falling edge and on entry to SEND;
  - it runs in SEND, ACK and WAIT_IDLE;
  - when it reaches `TIMEOUT_CYCLES`: both OEs → 0, pulse `ack_err`, → IDLE.
- Undefined: no watchdog logic is compiled, and the FSM waits indefinitely for device edges.

## Test plan
- Send 0xED with a device model that clocks at 12.5 kHz and acks → bits seen on device rising edges: 0, 1,0,1,1,0,1,1,1, parity 1, stop 1. Edge 11 is acked; one `done` pulse, no `ack_err`.
- Send 0xF4 → data bits 0,0,1,0,1,1,1,1, parity 0. `ps2_clk_oe` high for exactly 10001 cycles before release.
- Device model never pulls data low at edge 11 → `ack_err` pulses once, `done` stays 0, bus released.
- Device model stops clocking after edge 4, with `PS2_TX_TIMEOUT_EN` defined and `TIMEOUT_CYCLES`=5000 → 5000 cycles after edge 4, both OEs are 0 and `ack_err` pulses. Without the macro, `busy` stays 1.
- `tx_start` with 0x55 during a busy transfer of 0xED → ignored; the wire shows only 0xED.
- `rst` asserted mid-SEND (after edge 6) → both OEs 0 within the same cycle, `busy`=0, no pulses. A subsequent send of 0xF4 completes normally.
